// File: rtl/wta_pkg.sv
// Shared types and helpers for the winner-take-all round scheduler.
package wta_pkg;
  localparam int N_CH_DEF = 8;
  localparam int KW_DEF   = 4;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

  // Out-of-range k (zero or wider than the channel count) means "wait for all channels".
  function automatic int unsigned k_clamp(input int unsigned k, input int unsigned n);
    return (k == 0 || k > n) ? n : k;
  endfunction
endpackage

// File: rtl/wta_popcount.sv
// Combinational population count of an N_CH-bit vector.
module wta_popcount
  import wta_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int KW   = KW_DEF
) (
  input  logic [N_CH-1:0] vec_i,
  output logic [KW-1:0]   cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N_CH; i++) cnt_o = cnt_o + KW'(vec_i[i]);
  end
endmodule

// File: rtl/wta_round_sched.sv
// One inference round: clear the front end, track first and k-nearest fallers,
// bound the round by a timeout, then hand the result over valid/ready.
module wta_round_sched
  import wta_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int KW      = KW_DEF,
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [KW-1:0]   i_k,
  input  logic [N_CH-1:0] i_fall,
  input  logic            i_ready,
  output logic            o_clr,
  output logic            o_busy,
  output logic            o_valid,
  output logic [N_CH-1:0] o_nn,
  output logic [N_CH-1:0] o_knn,
  output logic [KW-1:0]   o_count,
  output logic            o_timeout
);
  state_e            state_q;
  logic [N_CH-1:0]   seen_q, seen_d, new_fall;
  logic [KW-1:0]     k_q, cnt_d;
  logic [TMO_W-1:0]  timer_q;
  logic              clr_q, busy_q, valid_q, tmo_q;
  logic [N_CH-1:0]   nn_q, knn_q;
  logic [KW-1:0]     count_q;

  // Only first falls of a channel count; repeats are masked by the seen set.
  assign new_fall = i_fall & ~seen_q;
  assign seen_d   = seen_q | new_fall;

  wta_popcount #(.N_CH(N_CH), .KW(KW)) u_pop (
    .vec_i (seen_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seen_q  <= '0;
      k_q     <= '0;
      timer_q <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      nn_q    <= '0;
      knn_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          clr_q <= 1'b0;
          if (i_start) begin
            k_q     <= KW'(k_clamp(32'(i_k), 32'(N_CH)));
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_q <= 1'b0;
          if (i_abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            seen_q  <= '0;
            timer_q <= '0;
            nn_q    <= '0;
            knn_q   <= '0;
            count_q <= '0;
            tmo_q   <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            seen_q  <= seen_d;
            timer_q <= timer_q + 1'b1;
            if (seen_q == '0 && new_fall != '0) nn_q <= new_fall;
            // k reached takes precedence over a coincident timeout.
            if (cnt_d >= k_q) begin
              knn_q   <= seen_d;
              count_q <= cnt_d;
              tmo_q   <= 1'b0;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else if (timer_q == TMO_W'(TIMEOUT - 1)) begin
              knn_q   <= seen_d;
              count_q <= cnt_d;
              tmo_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_clr     = clr_q;
  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_nn      = nn_q;
  assign o_knn     = knn_q;
  assign o_count   = count_q;
  assign o_timeout = tmo_q;
endmodule

// File: tb/tb_wta_round_sched.sv
// Directed bench for wta_round_sched with hand-computed expectations.
module tb_wta_round_sched;
  localparam int N_CH    = 8;
  localparam int KW      = 4;
  localparam int TMO_W   = 16;
  localparam int TIMEOUT = 20;

  logic            clk = 1'b0;
  logic            rst, i_start, i_abort, i_ready;
  logic [KW-1:0]   i_k;
  logic [N_CH-1:0] i_fall;
  logic            o_clr, o_busy, o_valid, o_timeout;
  logic [N_CH-1:0] o_nn, o_knn;
  logic [KW-1:0]   o_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wta_round_sched #(.N_CH(N_CH), .KW(KW), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_k(i_k),
    .i_fall(i_fall), .i_ready(i_ready), .o_clr(o_clr), .o_busy(o_busy),
    .o_valid(o_valid), .o_nn(o_nn), .o_knn(o_knn), .o_count(o_count),
    .o_timeout(o_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".clr"},   32'(o_clr),     32'h0);
    chk({tag, ".busy"},  32'(o_busy),    32'h0);
    chk({tag, ".valid"}, 32'(o_valid),   32'h0);
    chk({tag, ".nn"},    32'(o_nn),      32'h0);
    chk({tag, ".knn"},   32'(o_knn),     32'h0);
    chk({tag, ".count"}, 32'(o_count),   32'h0);
    chk({tag, ".tmo"},   32'(o_timeout), 32'h0);
  endtask

  // Start pulse, then the CLEAR cycle; returns with RUN cycle 0 next.
  task automatic start_round(input logic [KW-1:0] k, input string tag);
    i_k = k; i_start = 1'b1;
    step();
    chk({tag, ".clr_hi"},  32'(o_clr),  32'h1);
    chk({tag, ".busy_hi"}, 32'(o_busy), 32'h1);
    i_start = 1'b0;
    step();
    chk({tag, ".clr_lo"},  32'(o_clr),  32'h0);
  endtask

  task automatic run_cyc(input logic [N_CH-1:0] f);
    i_fall = f;
    step();
    i_fall = '0;
  endtask

  task automatic accept(input string tag);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({tag, ".acc_valid"}, 32'(o_valid), 32'h0);
    chk({tag, ".acc_busy"},  32'(o_busy),  32'h0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0; i_k = '0; i_fall = '0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(o_busy), 32'h0);

    // Basic round, k=3: ch5@4, ch2@9, ch7@12.
    start_round(4'd3, "basic");
    for (int r = 0; r <= 12; r++) begin
      run_cyc(r == 4 ? 8'h20 : r == 9 ? 8'h04 : r == 12 ? 8'h80 : 8'h00);
      if (r == 4)  chk("basic.nn_early", 32'(o_nn), 32'h20);
      if (r == 11) chk("basic.valid_lo", 32'(o_valid), 32'h0);
    end
    chk("basic.valid", 32'(o_valid),   32'h1);
    chk("basic.nn",    32'(o_nn),      32'h20);
    chk("basic.knn",   32'(o_knn),     32'hA4);
    chk("basic.count", 32'(o_count),   32'h3);
    chk("basic.tmo",   32'(o_timeout), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("basic.hold_valid", 32'(o_valid), 32'h1);
      chk("basic.hold_knn",   32'(o_knn),   32'hA4);
    end
    accept("basic");
    chk("basic.post_knn", 32'(o_knn), 32'hA4);

    // Tie on ch1+ch3, then a repeat on ch1.
    start_round(4'd2, "tie");
    chk("tie.nn_clr",  32'(o_nn),  32'h0);
    chk("tie.knn_clr", 32'(o_knn), 32'h0);
    run_cyc(8'h0A);
    chk("tie.valid", 32'(o_valid), 32'h1);
    chk("tie.nn",    32'(o_nn),    32'h0A);
    chk("tie.knn",   32'(o_knn),   32'h0A);
    chk("tie.count", 32'(o_count), 32'h2);
    run_cyc(8'h02);
    chk("tie.rep_knn",   32'(o_knn),   32'h0A);
    chk("tie.rep_count", 32'(o_count), 32'h2);
    accept("tie");

    // Timeout with k=4, only ch0 falls.
    start_round(4'd4, "tmo");
    for (int r = 0; r < TIMEOUT; r++) begin
      run_cyc(r == 2 ? 8'h01 : 8'h00);
      if (r == TIMEOUT - 2) chk("tmo.valid_lo", 32'(o_valid), 32'h0);
    end
    chk("tmo.valid", 32'(o_valid),   32'h1);
    chk("tmo.tmo",   32'(o_timeout), 32'h1);
    chk("tmo.knn",   32'(o_knn),     32'h01);
    chk("tmo.count", 32'(o_count),   32'h1);
    chk("tmo.nn",    32'(o_nn),      32'h01);
    accept("tmo");

    // k=0 clamps to all channels.
    start_round(4'd0, "k0");
    for (int r = 0; r < 8; r++) begin
      run_cyc(8'(1 << r));
      if (r == 6) chk("k0.valid_lo", 32'(o_valid), 32'h0);
    end
    chk("k0.valid", 32'(o_valid), 32'h1);
    chk("k0.knn",   32'(o_knn),   32'hFF);
    chk("k0.count", 32'(o_count), 32'h8);
    chk("k0.tmo",   32'(o_timeout), 32'h0);
    accept("k0");

    // k=9 clamps too; ch0 repeats so completion slips one cycle.
    start_round(4'd9, "k9");
    for (int r = 0; r <= 8; r++) begin
      run_cyc(r < 2 ? 8'h01 : 8'(1 << (r - 1)));
      if (r == 7) chk("k9.valid_lo", 32'(o_valid), 32'h0);
    end
    chk("k9.valid", 32'(o_valid), 32'h1);
    chk("k9.knn",   32'(o_knn),   32'hFF);
    chk("k9.count", 32'(o_count), 32'h8);
    accept("k9");

    // Abort in RUN.
    start_round(4'd3, "abort");
    run_cyc(8'h10);
    chk("abort.nn", 32'(o_nn), 32'h10);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort.busy",  32'(o_busy),  32'h0);
    chk("abort.valid", 32'(o_valid), 32'h0);
    run_cyc(8'hFF);
    run_cyc(8'hFF);
    chk("abort.idle_busy",  32'(o_busy),  32'h0);
    chk("abort.idle_valid", 32'(o_valid), 32'h0);
    chk("abort.keep_nn",    32'(o_nn),    32'h10);

    // Back-pressure in DONE with start/abort noise.
    start_round(4'd1, "bp");
    run_cyc(8'h40);
    chk("bp.valid", 32'(o_valid), 32'h1);
    chk("bp.knn",   32'(o_knn),   32'h40);
    for (int c = 0; c < 5; c++) begin
      i_start = c[0]; i_abort = ~c[0]; i_k = 4'd5; i_fall = 8'hFF;
      step();
      chk("bp.hold_valid", 32'(o_valid), 32'h1);
      chk("bp.hold_knn",   32'(o_knn),   32'h40);
      chk("bp.hold_count", 32'(o_count), 32'h1);
      chk("bp.no_clr",     32'(o_clr),   32'h0);
    end
    i_start = 1'b0; i_abort = 1'b0; i_fall = '0;
    accept("bp");
    step();
    chk("bp.no_restart", 32'(o_busy), 32'h0);

    // Mid-round reset after two falls.
    start_round(4'd5, "mrst");
    run_cyc(8'h01);
    run_cyc(8'h02);
    chk("mrst.nn", 32'(o_nn), 32'h01);
    rst = 1'b1;
    step();
    chk_zero("mrst");
    rst = 1'b0;
    run_cyc(8'hFF);
    run_cyc(8'hFF);
    chk_zero("mrst_idle");
    start_round(4'd1, "mrst2");
    run_cyc(8'h08);
    chk("mrst2.valid", 32'(o_valid), 32'h1);
    chk("mrst2.nn",    32'(o_nn),    32'h08);
    chk("mrst2.knn",   32'(o_knn),   32'h08);
    accept("mrst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
